noc_msg_arbiter: RTL

- Message-granular round-robin arbiter sharing one NoC output channel among NUM_REQ valid/ready input streams, typically the outputs of per-source message buffers in the chipset.
- Grant is locked for a whole message: from the header flit through the tail flit, using the header length field.
- Flits pass through combinationally while a grant is held, so there is no data latency once granted.

---
 rtl/noc_msg_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/noc_msg_arbiter.sv
// noc_msg_arbiter
// Message-granular round-robin arbiter. One NoC output channel is shared by
// NUM_REQ valid/ready input streams. A grant is held from the header flit
// through the tail flit. The header length field gives the number of payload
// flits that follow. While a grant is held, flits pass straight through
// without added latency. Each message costs one arbitration cycle in IDLE.
module noc_msg_arbiter #(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 64,
    parameter  int LEN_LSB    = 22,
    parameter  int LEN_WIDTH  = 8,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_REQ-1:0]            valid_in,
    output logic [NUM_REQ-1:0]            ready_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("noc_msg_arbiter: NUM_REQ must be within 2..8");
    end
    if (LEN_LSB + LEN_WIDTH > DATA_WIDTH) begin : g_bad_len_field
        $error("noc_msg_arbiter: length field exceeds flit width");
    end

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_FORWARD = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;

    logic [GW-1:0]          grant_q;      // current / last granted requester
    logic [GW-1:0]          rr_ptr_q;     // search start for the next grant
    logic [LEN_WIDTH-1:0]   rem_q;        // payload flits still to forward
    logic                   hdr_pending_q; // next granted flit is the header

    logic [DATA_WIDTH-1:0]  req_data [NUM_REQ];
    logic [DATA_WIDTH-1:0]  gnt_data;
    logic                   gnt_valid;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic                   out_xfer;
    logic                   is_tail;
    logic                   tail_xfer;

    logic                   pick_valid;
    logic [GW-1:0]          pick_id;
    logic [GW-1:0]          cand;
    logic [GW-1:0]          rr_ptr_next;

    // ------------------------------------------------------------------
    // Unpack the flat input bus into one flit per requester
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Select the granted stream and classify its current flit
    always_comb begin
        gnt_data  = req_data[grant_q];
        gnt_valid = valid_in[grant_q];
        hdr_len   = gnt_data[LEN_LSB +: LEN_WIDTH];
        out_xfer  = (state_q == ST_FORWARD) && gnt_valid && ready_out;
        // A header with length 0 is its own tail; otherwise the tail is the
        // body flit that brings the remaining count down from one.
        is_tail   = hdr_pending_q ? (hdr_len == '0) : (rem_q == LEN_WIDTH'(1));
        tail_xfer = out_xfer && is_tail;
    end

    // Round-robin pick: first set valid bit searching upward from rr_ptr
    always_comb begin
        // NOTE: every variable written here is given a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        pick_valid = |valid_in;
        pick_id    = '0;
        cand       = '0;
        // Scan from the far end back toward rr_ptr so the closest set bit is
        // the last one written and therefore wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (valid_in[cand]) begin
                pick_id = cand;
            end
        end
        rr_ptr_next = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + GW'(1);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant from IDLE on any request, release on tail transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (tail_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pass the granted stream through, everything quiet in IDLE
    always_comb begin
        ready_in  = '0;
        valid_out = 1'b0;
        data_out  = '0;
        if (state_q == ST_FORWARD) begin
            valid_out         = gnt_valid;
            data_out          = gnt_data;
            // ready depends only on the grant and downstream, never on valid
            ready_in[grant_q] = ready_out;
        end
    end

    assign busy     = (state_q == ST_FORWARD);
    assign grant_id = grant_q;

    // ------------------------------------------------------------------
    // Grant, round-robin pointer and flit counter
    // ------------------------------------------------------------------

    // Latch the winner on grant; track header/payload progress on transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            rem_q         <= '0;
            hdr_pending_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                grant_q       <= pick_id;
                rr_ptr_q      <= rr_ptr_next;
                hdr_pending_q <= 1'b1;
            end
        end else if (out_xfer) begin
            if (hdr_pending_q) begin
                rem_q         <= hdr_len;
                hdr_pending_q <= 1'b0;
            end else if (rem_q != '0) begin
                // Saturating decrement keeps rem from wrapping
                rem_q <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Simulation-only protocol checks
    // ------------------------------------------------------------------
    logic vld_seen_q;

    // Remember that the granted source had a flit waiting that was not its tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_seen_q <= 1'b0;
        end else begin
            vld_seen_q <= (state_q == ST_FORWARD) && gnt_valid && !tail_xfer;
        end
    end

    // Flag a granted source that withdraws valid mid-message; ready is one-hot
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(vld_seen_q && (state_q == ST_FORWARD) && !gnt_valid))
                else $warning("noc_msg_arbiter: valid_in[%0d] dropped mid-message", grant_q);
            assert ($onehot0(ready_in))
                else $error("noc_msg_arbiter: more than one ready_in bit set");
        end
    end

endmodule
